// File: rtl/tdt_dmi_apb_mux.sv
// DMI-side APB decoder: routes one DTM master transfer to one of SLAVE_NUM
// debug-module slaves through a registered SETUP/ACCESS sequence.
module tdt_dmi_apb_mux #(
  parameter int SLAVE_NUM   = 2,
  parameter int HIGH_ADDR_W = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      sys_apb_clk,
  input  logic                      sys_apb_rst_b,
  input  logic [12+HIGH_ADDR_W-1:0] pad_tdt_dmi_paddr,
  input  logic                      pad_tdt_dmi_psel,
  input  logic                      pad_tdt_dmi_penable,
  input  logic                      pad_tdt_dmi_pwrite,
  input  logic [31:0]               pad_tdt_dmi_pwdata,
  output logic [31:0]               tdt_dmi_pad_prdata,
  output logic                      tdt_dmi_pad_pready,
  output logic                      tdt_dmi_pad_pslverr,
  output logic [11:0]               tdt_dmi_paddr,
  output logic [SLAVE_NUM-1:0]      tdt_dmi_psel,
  output logic                      tdt_dmi_penable,
  output logic                      tdt_dmi_pwrite,
  output logic [31:0]               tdt_dmi_pwdata,
  input  logic [32*SLAVE_NUM-1:0]   tdt_dmi_prdata,
  input  logic [SLAVE_NUM-1:0]      tdt_dmi_pready,
  input  logic [SLAVE_NUM-1:0]      tdt_dmi_pslverr
);

  localparam int AW    = 12 + HIGH_ADDR_W;
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0]     TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [HIGH_ADDR_W:0] SLV_LIMIT   = (HIGH_ADDR_W + 1)'(SLAVE_NUM);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SLAVE_NUM-1:0] psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic [11:0]          paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic                 pad_pready_q, pad_pready_d;
  logic                 pad_pslverr_q, pad_pslverr_d;
  logic [31:0]          pad_prdata_q, pad_prdata_d;

  logic [HIGH_ADDR_W-1:0] idx_s;
  logic                   idx_valid_s;
  logic [SLAVE_NUM-1:0]   dec_oh_s;
  logic                   sel_ready_s;
  logic                   sel_err_s;
  logic [31:0]            sel_rdata_s;
  logic                   timeout_s;
  logic                   unused_s;

  // The master's penable plays no part in starting a capture.
  assign unused_s    = pad_tdt_dmi_penable;
  assign idx_s       = pad_tdt_dmi_paddr[AW-1:12];
  assign idx_valid_s = ({1'b0, idx_s} < SLV_LIMIT);
  assign timeout_s   = (TIMEOUT_CYC != 0) && (cnt_q == TIMEOUT_VAL);

  // Slave index decode to one-hot select.
  always_comb begin
    dec_oh_s = '0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      dec_oh_s[i] = (idx_s == HIGH_ADDR_W'(i));
    end
  end

  // Response mux keyed off the registered one-hot select.
  always_comb begin
    sel_ready_s = 1'b0;
    sel_err_s   = 1'b0;
    sel_rdata_s = 32'h0000_0000;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      sel_ready_s = sel_ready_s | (tdt_dmi_pready[i] & psel_q[i]);
      sel_err_s   = sel_err_s | (tdt_dmi_pslverr[i] & psel_q[i]);
      sel_rdata_s = sel_rdata_s | (tdt_dmi_prdata[32*i +: 32] & {32{psel_q[i]}});
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pad_pready_d  = 1'b0;
    pad_pslverr_d = pad_pslverr_q;
    pad_prdata_d  = pad_prdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pad_tdt_dmi_psel) begin
          paddr_d  = pad_tdt_dmi_paddr[11:0];
          pwrite_d = pad_tdt_dmi_pwrite;
          pwdata_d = pad_tdt_dmi_pwdata;
          if (idx_valid_s) begin
            psel_d  = dec_oh_s;
            state_d = ST_SETUP;
          end else begin
            pad_pready_d  = 1'b1;
            pad_pslverr_d = 1'b1;
            pad_prdata_d  = 32'h0000_0000;
            state_d       = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A ready in the timeout cycle still returns the slave's answer.
        if (sel_ready_s) begin
          psel_d        = '0;
          penable_d     = 1'b0;
          pad_pready_d  = 1'b1;
          pad_pslverr_d = sel_err_s;
          pad_prdata_d  = pwrite_q ? 32'h0000_0000 : sel_rdata_s;
          state_d       = ST_RESP;
        end else if (timeout_s) begin
          psel_d        = '0;
          penable_d     = 1'b0;
          pad_pready_d  = 1'b1;
          pad_pslverr_d = 1'b1;
          pad_prdata_d  = 32'h0000_0000;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        cnt_d         = '0;
        pad_pslverr_d = 1'b0;
        pad_prdata_d  = 32'h0000_0000;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d       = ST_IDLE;
        cnt_d         = '0;
        psel_d        = '0;
        penable_d     = 1'b0;
        pad_pslverr_d = 1'b0;
        pad_prdata_d  = 32'h0000_0000;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sys_apb_clk) begin
    if (!sys_apb_rst_b) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      paddr_q       <= 12'h000;
      pwrite_q      <= 1'b0;
      pwdata_q      <= 32'h0000_0000;
      pad_pready_q  <= 1'b0;
      pad_pslverr_q <= 1'b0;
      pad_prdata_q  <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pad_pready_q  <= pad_pready_d;
      pad_pslverr_q <= pad_pslverr_d;
      pad_prdata_q  <= pad_prdata_d;
    end
  end

  assign tdt_dmi_psel        = psel_q;
  assign tdt_dmi_penable     = penable_q;
  assign tdt_dmi_paddr       = paddr_q;
  assign tdt_dmi_pwrite      = pwrite_q;
  assign tdt_dmi_pwdata      = pwdata_q;
  assign tdt_dmi_pad_pready  = pad_pready_q;
  assign tdt_dmi_pad_pslverr = pad_pslverr_q;
  assign tdt_dmi_pad_prdata  = pad_prdata_q;

endmodule

// File: doc/tdt_dmi_apb_mux.md
Name: tdt_dmi_apb_mux

Overview:
- Parametrised DMI-side APB bridge/decoder that sits between the DTM's APB master port and up to SLAVE_NUM debug-module APB slaves, e.g. one per hart cluster.
- Decodes the high address bits to select one slave and re-times the transfer through a registered FSM.
- Returns the slave's response, or generates a SLVERR response for unmapped addresses and hung slaves (timeout).
- Successor to the single-slave DMI APB connection; the slave count and timeout are now configurable.

Parameters:
- SLAVE_NUM, 2: number of APB slaves (1..16).
- HIGH_ADDR_W, 2: upper address bits used for slave select; 2^HIGH_ADDR_W >= SLAVE_NUM.
- TIMEOUT_CYC, 255: maximum ACCESS cycles without pready before abort; 0 disables the timeout.

Ports:
- sys_apb_clk  in  1  APB clock, rising edge.
- sys_apb_rst_b  in  1  reset, synchronous, active-low.
- pad_tdt_dmi_paddr  in  12+HIGH_ADDR_W  master address; [11:0] slave offset, top bits select the slave.
- pad_tdt_dmi_psel  in  1  master select.
- pad_tdt_dmi_penable  in  1  master enable.
- pad_tdt_dmi_pwrite  in  1  master write.
- pad_tdt_dmi_pwdata  in  32  master write data.
- tdt_dmi_pad_prdata  out  32  read data to master.
- tdt_dmi_pad_pready  out  1  ready to master.
- tdt_dmi_pad_pslverr  out  1  error to master.
- tdt_dmi_paddr  out  12  slave offset address.
- tdt_dmi_psel  out  SLAVE_NUM  one-hot slave select.
- tdt_dmi_penable  out  1  slave enable.
- tdt_dmi_pwrite  out  1  slave write.
- tdt_dmi_pwdata  out  32  slave write data.
- tdt_dmi_prdata  in  32*SLAVE_NUM  slave read data; slave i occupies [32i+31:32i].
- tdt_dmi_pready  in  SLAVE_NUM  per-slave ready.
- tdt_dmi_pslverr  in  SLAVE_NUM  per-slave error.

Behaviour:
- Clock and reset: sys_apb_clk only, with sys_apb_rst_b synchronous active-low. Every flop is reset on a rising edge where sys_apb_rst_b=0.
- Reset values:
  - FSM = IDLE.
  - tdt_dmi_psel=0, tdt_dmi_penable=0, tdt_dmi_paddr=0, tdt_dmi_pwrite=0, tdt_dmi_pwdata=0.
  - tdt_dmi_pad_pready=0, tdt_dmi_pad_pslverr=0, tdt_dmi_pad_prdata=0.
  - Timeout counter = 0.
- All outputs are registered.
- IDLE:
  - On pad_tdt_dmi_psel=1, capture addr, pwrite, pwdata and idx = paddr[12+HIGH_ADDR_W-1:12].
  - If idx < SLAVE_NUM, go to SETUP. Otherwise go to RESP with prdata=0 and pslverr=1; no slave psel is asserted.
- SETUP: tdt_dmi_psel[idx]=1, penable=0, and the captured addr/pwrite/pwdata are driven. Always go to ACCESS.
- ACCESS: psel[idx]=1, penable=1. The counter increments every cycle in which tdt_dmi_pready[idx]=0.
  - pready[idx]=1: latch prdata slice idx (writes return 0) and pslverr[idx], drop psel/penable, go to RESP.
  - Timeout: TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC with no pready. Drop psel/penable, set prdata=0 and pslverr=1, go to RESP. A pready arriving in that same cycle wins over the timeout.
- RESP: tdt_dmi_pad_pready=1 for exactly one cycle, with pad_prdata/pad_pslverr valid. Clear the counter and return to IDLE.
- Master handshake:
  - The master holds psel/penable/addr/data stable until pad_pready.
  - pad_penable is not required for capture; a new capture needs psel high in IDLE.
  - The master deasserts psel in the cycle after pready, so a psel still high on the IDLE return cycle is treated as a new transfer.
  - If the master drops psel mid-transfer, the slave transfer still completes and RESP is still issued.
- Latency (zero-wait slave): master psel sampled at edge T → slave SETUP at T+1 → ACCESS at T+2 → pad_pready at T+3.
  - Decode error: pad_pready at T+1.
  - Timeout: pad_pready TIMEOUT_CYC+3 cycles after psel.
- Invariants:
  - At most one bit of tdt_dmi_psel is set.
  - penable=1 only when psel != 0.
  - pslverr is only meaningful while pad_pready=1.
- Reset mid-transfer: all outputs return to reset values on the next edge. The slave transfer is abandoned and no response is given.

Test Plan:
- Read slave 0: SLAVE_NUM=2, addr 0x010, slave0 pready=1 immediately, prdata=0x1234_5678 → tdt_dmi_psel=2'b01 for 2 cycles; pad_pready at T+3 with prdata=0x1234_5678, pslverr=0.
- Write slave 1 with wait states: addr 0x1044, wdata 0xA5A5_0001, slave1 pready after 3 ACCESS cycles → paddr=0x044, pwrite=1, psel=2'b10; pad_pready at T+5, pslverr=0.
- Unmapped address: addr 0x3000, SLAVE_NUM=2 → psel stays 0; pad_pready at T+1 with pslverr=1, prdata=0.
- Hung slave: TIMEOUT_CYC=4, slave0 never ready → psel dropped after 4 ACCESS cycles; pad_pready=1 with pslverr=1, prdata=0; next transfer proceeds normally.
- Slave error plus back-to-back: slave1 returns pslverr=1 → pad_pslverr=1; immediate second read to slave0 → FSM returns through IDLE, pslverr=0, one-hot psel correct.
- Reset mid-ACCESS: assert sys_apb_rst_b=0 for 1 cycle → all outputs 0 on the next edge, FSM IDLE, no pad_pready.
